// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: FSM states and shift direction.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next register value and the bit shifted out.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  dir_e             dir,
  input  logic             rotate,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    if (dir == DIR_LEFT) begin
      q_next  = {q[WIDTH-2:0], (rotate ? q[WIDTH-1] : sin)};
      out_bit = q[WIDTH-1];
    end else begin
      q_next  = {(rotate ? q[0] : sin), q[WIDTH-1:1]};
      out_bit = q[0];
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus counted burst shift/rotate in
// either direction, with busy/done handshake.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             dir,
  input  logic             rotate,
  input  logic             sin,
  output logic [WIDTH-1:0] parallel_out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             rot_q, rot_d;

  logic [WIDTH-1:0] step_q;
  logic             step_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q_q),
    .dir     (dir_q),
    .rotate  (rot_q),
    .sin     (sin),
    .q_next  (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          q_d = data_in;
        end else if (start) begin
          // A zero-length burst completes immediately without entering SHIFT.
          if (shift_count == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = shift_count;
            dir_d   = dir_e'(dir);
            rot_d   = rotate;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        q_d    = step_q;
        sout_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  assign parallel_out = q_q;
  assign sout         = sout_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH = 8) with hand-computed expectations.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic [CNT_W-1:0] shift_count;
  logic             dir;
  logic             rotate;
  logic             sin;
  logic [WIDTH-1:0] parallel_out;
  logic             sout;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int busy_cycles;

  univ_shift_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .data_in      (data_in),
    .start        (start),
    .shift_count  (shift_count),
    .dir          (dir),
    .rotate       (rotate),
    .sin          (sin),
    .parallel_out (parallel_out),
    .sout         (sout),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] po, input logic so,
                         input logic bz, input logic dn);
    chk({tag, ".po"},   32'(parallel_out), 32'(po));
    chk({tag, ".sout"}, 32'(sout),         32'(so));
    chk({tag, ".busy"}, 32'(busy),         32'(bz));
    chk({tag, ".done"}, 32'(done),         32'(dn));
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; data_in = '0; start = 1'b0;
    shift_count = '0; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
    #3;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    #9 reset_n = 1'b1;

    // Load A5
    tick();
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    chk_out("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Left shift in sin=1, count 3
    start = 1'b1; shift_count = 4'd3; dir = 1'b0; rotate = 1'b0; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_out("lsh_k", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("lsh_1", 8'h4B, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("lsh_2", 8'h97, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("lsh_3", 8'h2F, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("lsh_after", 8'h2F, 1'b1, 1'b0, 1'b0);

    // Right rotate by 1 on A5
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    start = 1'b1; shift_count = 4'd1; dir = 1'b1; rotate = 1'b1; sin = 1'b0;
    tick();
    start = 1'b0;
    chk_out("rrot_k", 8'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rrot_1", 8'hD2, 1'b1, 1'b0, 1'b1);

    // Zero count: done only, no busy, value unchanged
    tick();
    start = 1'b1; shift_count = 4'd0;
    tick();
    start = 1'b0;
    chk_out("cnt0", 8'hD2, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("cnt0_after", 8'hD2, 1'b1, 1'b0, 1'b0);

    // Full left rotate of A5 by 8
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    start = 1'b1; shift_count = 4'd8; dir = 1'b0; rotate = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      tick();
    end
    chk("rot8.busy_cycles", 32'(busy_cycles), 32'd8);
    chk_out("rot8_end", 8'hA5, 1'b1, 1'b0, 1'b1);

    // Mid-burst load/dir/start changes ignored: FF right-shift sin=0 by 2
    tick();
    load = 1'b1; data_in = 8'hFF;
    tick();
    load = 1'b0;
    start = 1'b1; shift_count = 4'd2; dir = 1'b1; rotate = 1'b0; sin = 1'b0;
    tick();
    load = 1'b1; data_in = 8'h00; dir = 1'b0; rotate = 1'b1; shift_count = 4'd5;
    tick();
    chk_out("ign_1", 8'h7F, 1'b1, 1'b1, 1'b0);
    tick();
    load = 1'b0; start = 1'b0;
    chk_out("ign_2", 8'h3F, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("ign_after", 8'h3F, 1'b1, 1'b0, 1'b0);

    // Back-to-back: left shift 1 with sin=1, then start in done cycle
    start = 1'b1; shift_count = 4'd1; dir = 1'b0; rotate = 1'b0; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_out("b2b_a_k", 8'h3F, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("b2b_a_done", 8'h7F, 1'b0, 1'b0, 1'b1);
    start = 1'b1; shift_count = 4'd2; dir = 1'b1; rotate = 1'b1;
    tick();
    start = 1'b0;
    chk_out("b2b_b_k", 8'h7F, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("b2b_b_1", 8'hBF, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("b2b_b_2", 8'hDF, 1'b1, 1'b0, 1'b1);

    // Reset during a count-5 burst
    tick();
    start = 1'b1; shift_count = 4'd5; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk_out("rst_mid_1", 8'hBE, 1'b1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    chk_out("rst_released", 8'h00, 1'b0, 1'b0, 1'b0);
    start = 1'b1; shift_count = 4'd1; dir = 1'b0; rotate = 1'b0; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_out("post_rst_k", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("post_rst_1", 8'h01, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
